// File: rtl/div_pkg.sv
// Shared types and default sizing for the clock-divider controller.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } state_t;

  localparam int DIV_W_DEFAULT     = 16;
  localparam int DIV_RATIO_DEFAULT = 5;

endpackage

// File: rtl/div_ctrl_if.sv
// Ratio configuration channel: valid/ready transfer of a new divide ratio plus an error pulse.
interface div_ctrl_if
  import div_pkg::*;
#(
  parameter int W = DIV_W_DEFAULT
);

  logic         cfg_valid;
  logic [W-1:0] cfg_div;
  logic         cfg_ready;
  logic         cfg_err;

  modport master (
    output cfg_valid,
    output cfg_div,
    input  cfg_ready,
    input  cfg_err
  );

  modport slave (
    input  cfg_valid,
    input  cfg_div,
    output cfg_ready,
    output cfg_err
  );

endinterface

// File: rtl/div_core.sv
// Period counter with wrap detect; tick/phase registered one cycle after the count they describe.
// restart or !run clears the counter and both outputs on the next edge.
module div_core
  import div_pkg::*;
#(
  parameter int W = DIV_W_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         run,
  input  logic         restart,
  input  logic [W-1:0] cur_div,
  output logic         wrap,
  output logic         tick,
  output logic         phase
);

  logic [W-1:0] cnt;

  assign wrap = run && !restart && (cnt == cur_div - W'(1));

  always_ff @(posedge clk) begin
    if (rst || restart || !run) begin
      cnt   <= '0;
      tick  <= 1'b0;
      phase <= 1'b0;
    end else begin
      cnt   <= wrap ? '0 : cnt + W'(1);
      tick  <= wrap;
      phase <= (cnt >= (cur_div >> 1));
    end
  end

endmodule

// File: rtl/div_ctrl.sv
// Programmable clock divider: FSM, ratio handshake and deferred ratio apply at period boundaries.
// cfg_ready drops while a ratio is pending; a new ratio never truncates or stretches a period.
module div_ctrl
  import div_pkg::*;
#(
  parameter int W       = DIV_W_DEFAULT,
  parameter int DEF_DIV = DIV_RATIO_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  div_ctrl_if.slave    cfg,
  output logic [W-1:0] cur_div,
  output logic         tick,
  output logic         phase,
  output logic         busy
);

  state_t       state, state_nxt;
  logic [W-1:0] pend_div, pend_nxt, cur_nxt;
  logic         wrap;
  logic         xfer;
  logic         accept;
  logic         cfg_err_q;

  assign cfg.cfg_ready = (state != PEND);
  assign cfg.cfg_err   = cfg_err_q;
  assign busy          = (state != IDLE);

  assign xfer   = cfg.cfg_valid && cfg.cfg_ready;
  assign accept = xfer && (cfg.cfg_div != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cur_div   <= W'(DEF_DIV);
      pend_div  <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      cur_div   <= cur_nxt;
      pend_div  <= pend_nxt;
      cfg_err_q <= xfer && (cfg.cfg_div == '0);
    end
  end

  always_comb begin
    state_nxt = state;
    cur_nxt   = cur_div;
    pend_nxt  = pend_div;
    unique case (state)
      IDLE: begin
        if (accept) cur_nxt = cfg.cfg_div;
        if (en) state_nxt = RUN;
      end
      RUN: begin
        if (!en) begin
          state_nxt = IDLE;
          if (accept) cur_nxt = cfg.cfg_div;
        end else if (accept) begin
          // On the wrap cycle the new ratio can take effect at once without cutting a period.
          if (wrap) begin
            cur_nxt = cfg.cfg_div;
          end else begin
            pend_nxt  = cfg.cfg_div;
            state_nxt = PEND;
          end
        end
      end
      PEND: begin
        if (!en) begin
          state_nxt = IDLE;
          cur_nxt   = pend_div;
        end else if (wrap) begin
          state_nxt = RUN;
          cur_nxt   = pend_div;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  div_core #(.W(W)) u_core (
    .clk     (clk),
    .rst     (rst),
    .run     (busy),
    .restart (busy && !en),
    .cur_div (cur_div),
    .wrap    (wrap),
    .tick    (tick),
    .phase   (phase)
  );

endmodule

// File: tb/tb_div_ctrl.sv
// Directed table-driven bench for div_ctrl with hand-computed per-cycle expectations.
module tb_div_ctrl;
  import div_pkg::*;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic [W-1:0] cur_div;
  logic         tick;
  logic         phase;
  logic         busy;

  div_ctrl_if #(.W(W)) cfg ();

  div_ctrl #(.W(W), .DEF_DIV(5)) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .cfg     (cfg),
    .cur_div (cur_div),
    .tick    (tick),
    .phase   (phase),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         rst;
    logic         en;
    logic         vld;
    logic [W-1:0] div;
    logic         tick;
    logic         phase;
    logic         busy;
    logic         rdy;
    logic         err;
    logic [W-1:0] cur;
  } vec_t;

  vec_t vecs[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic add(input logic r, input logic e, input logic v, input int d,
                     input logic t, input logic p, input logic b, input logic rd,
                     input logic er, input int c);
    vec_t x;
    x.rst = r; x.en = e; x.vld = v; x.div = W'(d);
    x.tick = t; x.phase = p; x.busy = b; x.rdy = rd; x.err = er; x.cur = W'(c);
    vecs.push_back(x);
  endtask

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  initial begin
    int n;
    rst = 1'b1; en = 1'b0; cfg.cfg_valid = 1'b0; cfg.cfg_div = '0;

    //  rst en vld div | tick ph busy rdy err cur
    add(1, 0, 0, 0,    0, 0, 0, 1, 0, 5);
    add(1, 1, 1, 7,    0, 0, 0, 1, 0, 5);  // reset beats en and cfg_valid
    add(0, 0, 1, 0,    0, 0, 0, 1, 1, 5);  // zero ratio in IDLE
    add(0, 0, 0, 0,    0, 0, 0, 1, 0, 5);
    add(0, 1, 0, 0,    0, 0, 1, 1, 0, 5);  // busy rises, cnt 0
    add(0, 1, 0, 0,    0, 0, 1, 1, 0, 5);
    add(0, 1, 0, 0,    0, 0, 1, 1, 0, 5);
    add(0, 1, 0, 0,    0, 1, 1, 1, 0, 5);
    add(0, 1, 0, 0,    0, 1, 1, 1, 0, 5);
    add(0, 1, 0, 0,    1, 1, 1, 1, 0, 5);  // first tick, 5 after busy
    add(0, 1, 0, 0,    0, 0, 1, 1, 0, 5);
    add(0, 1, 0, 0,    0, 0, 1, 1, 0, 5);
    add(0, 1, 0, 0,    0, 1, 1, 1, 0, 5);
    add(0, 1, 0, 0,    0, 1, 1, 1, 0, 5);
    add(0, 1, 0, 0,    1, 1, 1, 1, 0, 5);
    add(0, 1, 1, 0,    0, 0, 1, 1, 1, 5);  // zero ratio in RUN
    add(0, 1, 0, 0,    0, 0, 1, 1, 0, 5);
    add(0, 1, 0, 0,    0, 1, 1, 1, 0, 5);
    add(0, 1, 0, 0,    0, 1, 1, 1, 0, 5);
    add(0, 1, 0, 0,    1, 1, 1, 1, 0, 5);
    add(0, 1, 0, 0,    0, 0, 1, 1, 0, 5);
    add(0, 1, 1, 4,    0, 0, 1, 0, 0, 5);  // ratio 4 offered at cnt 1 -> PEND
    add(0, 1, 1, 9,    0, 1, 1, 0, 0, 5);  // ignored while not ready
    add(0, 1, 0, 0,    0, 1, 1, 0, 0, 5);
    add(0, 1, 0, 0,    1, 1, 1, 1, 0, 4);  // wrap applies 4
    add(0, 1, 0, 0,    0, 0, 1, 1, 0, 4);
    add(0, 1, 0, 0,    0, 0, 1, 1, 0, 4);
    add(0, 1, 0, 0,    0, 1, 1, 1, 0, 4);
    add(0, 1, 0, 0,    1, 1, 1, 1, 0, 4);
    add(0, 1, 0, 0,    0, 0, 1, 1, 0, 4);
    add(0, 1, 0, 0,    0, 0, 1, 1, 0, 4);
    add(0, 1, 0, 0,    0, 1, 1, 1, 0, 4);
    add(0, 1, 1, 8,    1, 1, 1, 1, 0, 8);  // offer on wrap cycle, no PEND
    add(0, 1, 0, 0,    0, 0, 1, 1, 0, 8);
    add(0, 1, 0, 0,    0, 0, 1, 1, 0, 8);
    add(0, 1, 0, 0,    0, 0, 1, 1, 0, 8);
    add(0, 1, 0, 0,    0, 0, 1, 1, 0, 8);
    add(0, 1, 0, 0,    0, 1, 1, 1, 0, 8);
    add(0, 1, 0, 0,    0, 1, 1, 1, 0, 8);
    add(0, 1, 0, 0,    0, 1, 1, 1, 0, 8);
    add(0, 1, 0, 0,    1, 1, 1, 1, 0, 8);
    add(0, 1, 0, 0,    0, 0, 1, 1, 0, 8);
    add(0, 1, 1, 3,    0, 0, 1, 0, 0, 8);  // pend 3
    add(0, 0, 0, 0,    0, 0, 0, 1, 0, 3);  // en drops in PEND, pend kept
    add(0, 0, 0, 0,    0, 0, 0, 1, 0, 3);
    add(0, 1, 0, 0,    0, 0, 1, 1, 0, 3);
    add(0, 1, 0, 0,    0, 0, 1, 1, 0, 3);
    add(0, 1, 0, 0,    0, 1, 1, 1, 0, 3);
    add(0, 1, 0, 0,    1, 1, 1, 1, 0, 3);  // tick 3 after restart
    add(0, 0, 1, 6,    0, 0, 0, 1, 0, 6);  // en falls with accept
    add(0, 1, 0, 0,    0, 0, 1, 1, 0, 6);
    add(0, 1, 0, 0,    0, 0, 1, 1, 0, 6);
    add(0, 1, 0, 0,    0, 0, 1, 1, 0, 6);
    add(0, 1, 0, 0,    0, 0, 1, 1, 0, 6);
    add(1, 1, 1, 2,    0, 0, 0, 1, 0, 5);  // reset mid-period
    add(0, 0, 0, 0,    0, 0, 0, 1, 0, 5);
    add(0, 0, 1, 1,    0, 0, 0, 1, 0, 1);
    add(0, 1, 0, 0,    0, 0, 1, 1, 0, 1);
    add(0, 1, 0, 0,    1, 1, 1, 1, 0, 1);  // N=1: tick and phase stay high
    add(0, 1, 0, 0,    1, 1, 1, 1, 0, 1);
    add(0, 0, 0, 0,    0, 0, 0, 1, 0, 1);

    for (int i = 0; i < vecs.size(); i++) begin
      rst           = vecs[i].rst;
      en            = vecs[i].en;
      cfg.cfg_valid = vecs[i].vld;
      cfg.cfg_div   = vecs[i].div;
      @(posedge clk); #1;
      chk("tick",      i, 32'(tick),          32'(vecs[i].tick));
      chk("phase",     i, 32'(phase),         32'(vecs[i].phase));
      chk("busy",      i, 32'(busy),          32'(vecs[i].busy));
      chk("cfg_ready", i, 32'(cfg.cfg_ready), 32'(vecs[i].rdy));
      chk("cfg_err",   i, 32'(cfg.cfg_err),   32'(vecs[i].err));
      chk("cur_div",   i, 32'(cur_div),       32'(vecs[i].cur));
    end

    // Accept in IDLE and start in the same cycle, then time ticks with a bounded wait.
    rst = 1'b0; en = 1'b1; cfg.cfg_valid = 1'b1; cfg.cfg_div = W'(2);
    @(posedge clk); #1;
    cfg.cfg_valid = 1'b0;
    chk("start_busy", 0, 32'(busy), 32'd1);
    chk("start_cur",  0, 32'(cur_div), 32'd2);
    n = 0;
    while (!tick && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("first_tick_latency", 0, 32'(n), 32'd2);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!tick && n < 20);
    chk("tick_interval", 0, 32'(n), 32'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/div_ctrl.md
DIV_CTRL -- requirements
Module: div_ctrl

Interface
REQ-001 The block SHALL have parameter W, default 16: width of divide ratio and period counter.
REQ-002 The block SHALL have parameter DEF_DIV, default 5: divide ratio loaded at reset, range 1..2^W-1.
REQ-003 The block SHALL have port clk, input, 1: single clock; all state updates on posedge clk.
REQ-004 The block SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-005 The block SHALL have port en, input, 1: run enable, level-sensitive.
REQ-006 The block SHALL have port cfg_valid, input, 1: a new ratio is offered.
REQ-007 The block SHALL have port cfg_div, input, W: offered ratio N.
REQ-008 The block SHALL have port cfg_ready, output, 1: ratio can be accepted this cycle.
REQ-009 The block SHALL have port cfg_err, output, 1: one-cycle pulse when an accepted cfg_div equals 0.
REQ-010 The block SHALL have port cur_div, output, W: ratio currently in effect.
REQ-011 The block SHALL have port tick, output, 1: one-cycle pulse, once per period.
REQ-012 The block SHALL have port phase, output, 1: divided level, low for N>>1 cycles, then high for the rest of the period.
REQ-013 The block SHALL have port busy, output, 1: high when the state is not IDLE.

Function
REQ-014 The block SHALL implement states IDLE, RUN and PEND (RUN with a ratio change waiting).
REQ-015 The block SHALL use a period counter cnt that counts 0..cur_div-1 in RUN/PEND and wraps to 0; the wrap cycle is the cycle where cnt==cur_div-1.
REQ-016 tick SHALL be registered and high exactly in the cycle after each wrap cycle; period between ticks = cur_div cycles.
REQ-017 phase SHALL be registered and equal (cnt >= cur_div>>1) with a one-cycle lag; with N=1, phase is constantly 1 and tick is constantly 1 while running.
REQ-018 Handshake: a transfer SHALL occur when cfg_valid && cfg_ready, and cfg_ready SHALL be 1 in IDLE and RUN and 0 in PEND.
REQ-019 An accepted cfg_div of 0 SHALL be discarded, pulse cfg_err for one cycle (next cycle), and leave state and cur_div unchanged.
REQ-020 An accept in IDLE SHALL load cur_div next cycle; cnt stays 0.
REQ-021 An accept in RUN outside the wrap cycle SHALL store the ratio in pend_div and go to PEND.
REQ-022 An accept in RUN on the wrap cycle SHALL apply directly to cur_div at that wrap; the state stays RUN.
REQ-023 In PEND, at the wrap cycle, the block SHALL copy pend_div to cur_div, reset cnt to 0, and go to RUN; no period is ever truncated or stretched.
REQ-024 IDLE to RUN SHALL occur when en=1; cnt starts at 0 in the first RUN cycle, and the first tick comes cur_div cycles after busy rises.
REQ-025 When en=0 in RUN or PEND, the next cycle SHALL go to IDLE with cnt=0, tick=0 and phase=0; a pending ratio is copied to cur_div (not lost).
REQ-026 If en falls in the same cycle as an accept, the accepted ratio SHALL become cur_div and the state SHALL be IDLE.
REQ-027 Changing cfg_div while cfg_valid=1 and cfg_ready=0 SHALL have no effect; only the value at the transfer cycle counts.

Reset
REQ-028 When rst=1 at a clock edge, the block SHALL set: state IDLE, cnt 0, pend_div 0, cur_div DEF_DIV, tick 0, phase 0, cfg_err 0, busy 0; cfg_ready reads 1 in the first cycle after reset.
REQ-029 rst SHALL override en and cfg_valid in the same cycle; reset mid-period discards the pending ratio.

Structure
REQ-030 Package div_pkg SHALL hold the state enum (IDLE/RUN/PEND) and the default W and DEF_DIV constants.
REQ-031 One sub-module, div_core, SHALL hold cnt, the wrap detect and the tick/phase registers; inputs are cur_div, run and restart.
REQ-032 div_ctrl SHALL hold the FSM, the handshake, pend_div and cfg_err.

Verification
REQ-033 Reset, then en=1 with DEF_DIV=5 -> tick every 5 cycles; phase low 2 and high 3 cycles per period; busy=1.
REQ-034 Running N=5, offer cfg_div=4 at cnt=1 -> cfg_ready drops; the current period completes at 5 cycles; the following periods are 4 cycles; cur_div changes at the wrap.
REQ-035 Offer cfg_div=8 exactly on the wrap cycle -> accepted, no PEND; the next period is 8 cycles.
REQ-036 Offer cfg_div=0 in IDLE and in RUN -> one-cycle cfg_err each time; cur_div and the tick period are unchanged.
REQ-037 en=0 while in PEND (pend 3), then en=1 -> busy drops for the idle span, cur_div=3, and the first tick comes 3 cycles after restart.
REQ-038 rst asserted mid-period with cfg_valid=1 -> all outputs reach their reset values next cycle; cur_div=5; nothing accepted.
